memory_stage: RTL

Pipeline MEM stage of the five-stage processor: consumes the registered EX/MEM outputs (ALU result, store data, negative flag, destination register) and produces the MEM/WB pipeline register. It contains the word-addressed data memory, a multi-cycle load sequencer that stalls upstream stages, and branch-on-negative resolution. The MEM/WB result also feeds back to the execute stage's `nextOutput` forwarding input.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/dmem_sync.sv | 33 +++
 rtl/memory_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the MEM pipeline stage: default memory geometry,
// default load latency, the load sequencer state encoding and a helper that
// turns a word depth into the width of the word index.
package mem_pkg;

   localparam int DEFAULT_DEPTH    = 256;
   localparam int DEFAULT_LOAD_LAT = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } loadState_t;

   // Number of bits needed to index DEPTH words.
   function automatic int idxWidth(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_sync.sv
// dmem_sync
// Single-port word-addressed data RAM: synchronous write, asynchronous read.
// Contents are never cleared; the array powers up undefined.
// Ports:
//   clock    - rising-edge clock
//   i_we     - write enable, memory[i_addr] takes i_wdata at the edge
//   i_addr   - word index shared by read and write
//   i_wdata  - 32-bit write data
//   o_rdata  - 32-bit combinational read of memory[i_addr]
module dmem_sync
   import mem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clock,
   input  logic                       i_we,
   input  logic [idxWidth(DEPTH)-1:0] i_addr,
   input  logic [31:0]                i_wdata,
   output logic [31:0]                o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // Write port: one word per edge, no reset so the array maps onto RAM.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// memory_stage
// MEM stage of the five-stage pipeline. Takes the registered EX/MEM outputs,
// performs stores and multi-cycle loads against the data memory, resolves
// branch-on-negative and produces the MEM/WB pipeline register.
// Ports:
//   clock, reset (synchronous, active-low)
//   ALUresult    - byte address for loads/stores, also the non-load result
//   outB         - store data
//   negF         - negative flag for branch-on-negative
//   regWriteSel  - destination register
//   memRead, memWrite, regWrite, memToReg, branchNeg - EX/MEM control bits
//   writeData, writeSel, writeEn - MEM/WB register outputs
//   stall        - hold request to upstream stages while a load is in flight
//   takeBranch   - combinational branchNeg & negF
//   alignErr     - one-cycle registered pulse for a suppressed misaligned access
module memory_stage
   import mem_pkg::*;
#(
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int LOAD_LAT = DEFAULT_LOAD_LAT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ALUresult,
   input  logic [31:0] outB,
   input  logic        negF,
   input  logic [4:0]  regWriteSel,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic        regWrite,
   input  logic        memToReg,
   input  logic        branchNeg,
   output logic [31:0] writeData,
   output logic [4:0]  writeSel,
   output logic        writeEn,
   output logic        stall,
   output logic        takeBranch,
   output logic        alignErr
);

   localparam int AW = idxWidth(DEPTH);

   // The first WAIT cycle starts with LOAD_LAT-2 so that the IDLE cycle plus
   // the WAIT cycles with a non-zero count add up to LOAD_LAT-1 stall cycles.
   localparam logic [2:0] CNT_START = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

   loadState_t  r_state;
   loadState_t  w_nextState;
   logic [2:0]  r_cnt;
   logic [2:0]  w_nextCnt;

   logic [31:0] r_writeData;
   logic [4:0]  r_writeSel;
   logic        r_writeEn;
   logic        r_alignErr;

   logic [AW-1:0] w_idx;
   logic [31:0]   w_rdata;
   logic          w_aligned;
   logic          w_memOp;
   logic          w_misaligned;
   logic          w_isStore;
   logic          w_isLoad;
   logic          w_memWe;
   logic          w_stallRaw;
   logic          w_wbUpdate;
   logic [31:0]   w_wbData;
   logic          w_wbEn;
   logic          w_unusedAddrHigh;

   // Address decode. Bits above the word index are dropped, so addresses
   // wrap modulo DEPTH*4. A read+write collision is treated as a store.
   assign w_idx            = ALUresult[AW+1:2];
   assign w_unusedAddrHigh = ^ALUresult[31:AW+2];
   assign w_aligned        = (ALUresult[1:0] == 2'b00);
   assign w_memOp          = memRead | memWrite;
   assign w_misaligned     = w_memOp & ~w_aligned;
   assign w_isStore        = memWrite & w_aligned;
   assign w_isLoad         = memRead & ~memWrite & w_aligned;

   // Stores commit only from IDLE and never while reset is held.
   assign w_memWe = w_isStore & (r_state == ST_IDLE) & reset;

   dmem_sync #(
      .DEPTH (DEPTH)
   ) uDmem (
      .clock   (clock),
      .i_we    (w_memWe),
      .i_addr  (w_idx),
      .i_wdata (outB),
      .o_rdata (w_rdata)
   );

   // Load sequencer next-state and MEM/WB source selection. By default the
   // MEM/WB register takes the ALU result; only an in-flight load replaces
   // that with a bubble or, on its final cycle, the memory word.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_stallRaw  = 1'b0;
      w_wbUpdate  = 1'b1;
      w_wbData    = ALUresult;
      w_wbEn      = regWrite & ~memWrite & ~w_misaligned;
      case (r_state)
         ST_IDLE: begin
            if (w_isLoad) begin
               if (LOAD_LAT > 1) begin
                  w_nextState = ST_WAIT;
                  w_nextCnt   = CNT_START;
                  w_stallRaw  = 1'b1;
                  w_wbUpdate  = 1'b0;
               end else begin
                  w_wbData = memToReg ? w_rdata : ALUresult;
                  w_wbEn   = regWrite;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt != 3'd0) begin
               w_nextCnt  = r_cnt - 3'd1;
               w_stallRaw = 1'b1;
               w_wbUpdate = 1'b0;
            end else begin
               w_nextState = ST_IDLE;
               w_wbData    = memToReg ? w_rdata : ALUresult;
               w_wbEn      = regWrite;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // State, counter and MEM/WB registers. A bubble clears writeEn but keeps
   // the previous data and destination so forwarding sees a stable value.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_writeData <= 32'd0;
         r_writeSel  <= 5'd0;
         r_writeEn   <= 1'b0;
         r_alignErr  <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_cnt      <= w_nextCnt;
         r_alignErr <= w_misaligned & (r_state == ST_IDLE);
         if (w_wbUpdate) begin
            r_writeData <= w_wbData;
            r_writeSel  <= regWriteSel;
            r_writeEn   <= w_wbEn;
         end else begin
            r_writeEn <= 1'b0;
         end
      end
   end

   // Stall is forced low while reset is held so upstream is released at once.
   assign stall      = w_stallRaw & reset;
   assign takeBranch = branchNeg & negF;
   assign writeData  = r_writeData;
   assign writeSel   = r_writeSel;
   assign writeEn    = r_writeEn;
   assign alignErr   = r_alignErr;

endmodule
